// File: rtl/block_accumulator.sv
// block_accumulator: sums blocks of N samples into a dividend/divisor pair for a truncating divider.
// Define BLOCK_ACCUMULATOR_ROUND_EN to add floor(N/2) to each sum so the divider rounds half-up.
module block_accumulator #(
  parameter int DATA_W = 8,
  parameter int N      = 5,
  parameter int SUM_W  = DATA_W + $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [DATA_W-1:0]    i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SUM_W-1:0]     o_dividend,
  output logic [SUM_W-1:0]     o_divisor,
  output logic [$clog2(N)-1:0] o_count
);
  localparam int CW = $clog2(N);
`ifdef BLOCK_ACCUMULATOR_ROUND_EN
  localparam logic [SUM_W-1:0] RND = SUM_W'(N / 2);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif
  logic [SUM_W-1:0] acc, out_q;
  logic [CW-1:0] cnt;
  logic last_slot, take, done;
  // only the block-completing sample can be blocked, and only by an unconsumed result
  always_comb begin
    last_slot = cnt == CW'(N - 1);
    o_ready = i_reset_n && !(last_slot && o_valid && !i_ready);
    take = i_valid && o_ready && !i_flush;
    done = take && last_slot;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc <= '0;
      cnt <= '0;
      out_q <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_flush || done) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc + SUM_W'(i_data);
        cnt <= cnt + CW'(1);
      end
      if (done) begin
        out_q <= acc + SUM_W'(i_data) + RND;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
  assign o_dividend = out_q;
  assign o_divisor = SUM_W'(N);
  assign o_count = cnt;
endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator: directed and randomized checks of block_accumulator against a queue-based model.
module tb_block_accumulator;
  localparam int N = 5;
  localparam int DATA_W = 8;
  localparam int SUM_W = DATA_W + $clog2(N);
  localparam int CW = $clog2(N);
`ifdef BLOCK_ACCUMULATOR_ROUND_EN
  localparam int RND = N / 2;
`else
  localparam int RND = 0;
`endif
  logic i_clk = 0, i_reset_n = 0, i_flush = 0, i_valid = 0, i_ready = 0;
  logic [DATA_W-1:0] i_data = '0;
  logic o_ready, o_valid;
  logic [SUM_W-1:0] o_dividend, o_divisor;
  logic [CW-1:0] o_count;
  int checks = 0, errors = 0;
  int mq[$];
  bit mv = 0;
  int md = 0;

  block_accumulator #(.DATA_W(DATA_W), .N(N)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_dividend(o_dividend), .o_divisor(o_divisor), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit model_ready(input bit r);
    return !(mq.size() == N - 1 && mv && !r);
  endfunction

  // a block's sum is the plain sum of its N accepted samples plus the rounding bias
  task automatic cycle(input bit v, input int d, input bit f, input bit r);
    bit rdy, fin;
    int s;
    i_valid = v; i_data = DATA_W'(d); i_flush = f; i_ready = r;
    rdy = model_ready(r);
    fin = 0;
    @(posedge i_clk);
    if (f) mq.delete();
    else if (v && rdy) begin
      mq.push_back(d);
      if (mq.size() == N) begin
        s = RND;
        foreach (mq[k]) s += mq[k];
        md = s; fin = 1; mq.delete();
      end
    end
    if (fin) mv = 1;
    else if (r) mv = 0;
    #1;
  endtask

  task automatic model_reset();
    mq.delete(); mv = 0; md = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", o_valid); end
    checks++; if (o_dividend !== '0) begin errors++; $display("FAIL reset_dividend: got %0d expected 0", o_dividend); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0d expected 0", o_ready); end
    checks++; if (o_divisor !== SUM_W'(N)) begin errors++; $display("FAIL reset_divisor: got %0d expected %0d", o_divisor, N); end
    @(negedge i_clk); i_reset_n = 1; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0d expected 1", o_ready); end
  endtask

  task automatic test_single_block();
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 10 * k, 0, 1);
      if (k == 4) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0d expected 0", o_valid); end
      end
    end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d expected 1", o_valid); end
    checks++; if (o_dividend !== SUM_W'(150 + RND)) begin errors++; $display("FAIL single_sum: got %0d expected %0d", o_dividend, 150 + RND); end
    checks++; if (o_divisor !== SUM_W'(N)) begin errors++; $display("FAIL single_divisor: got %0d expected %0d", o_divisor, N); end
    cycle(0, 0, 0, 1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %0d expected 0", o_valid); end
  endtask

  task automatic test_max_values();
    for (int k = 0; k < 5; k++) cycle(1, 255, 0, 1);
    checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(1275 + RND)) begin errors++; $display("FAIL max_sum: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, 1275 + RND); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_back_pressure();
    for (int k = 1; k <= 9; k++) cycle(1, k, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(15 + RND)) begin errors++; $display("FAIL bp_first: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, 15 + RND); end
    checks++; if (o_count !== CW'(4)) begin errors++; $display("FAIL bp_count: got %0d expected 4", o_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %0d expected 0", o_ready); end
    cycle(1, 10, 0, 0);
    checks++; if (o_dividend !== SUM_W'(15 + RND) || o_count !== CW'(4)) begin errors++; $display("FAIL bp_hold: got sum=%0d count=%0d expected sum=%0d count=4", o_dividend, o_count, 15 + RND); end
    i_ready = 1; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %0d expected 1", o_ready); end
    cycle(1, 10, 0, 1);
    checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(40 + RND)) begin errors++; $display("FAIL bp_second: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, 40 + RND); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL bp_count_wrap: got %0d expected 0", o_count); end
    cycle(0, 0, 0, 1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_consume: got %0d expected 0", o_valid); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cycle(1, 7, 0, 1);
    checks++; if (o_count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", o_count); end
    cycle(1, 99, 1, 1);
    checks++; if (o_count !== '0 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count=%0d valid=%0d expected 0 0", o_count, o_valid); end
    for (int k = 0; k < 5; k++) cycle(1, 2, 0, 1);
    checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(10 + RND)) begin errors++; $display("FAIL flush_sum: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, 10 + RND); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 5; k++) cycle(1, k, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_count !== CW'(3)) begin errors++; $display("FAIL rmid_setup: got valid=%0d count=%0d expected 1 3", o_valid, o_count); end
    #2 i_reset_n = 0; #1;
    model_reset();
    checks++; if (o_valid !== 1'b0 || o_dividend !== '0 || o_count !== '0) begin errors++; $display("FAIL rmid_async: got valid=%0d sum=%0d count=%0d expected 0 0 0", o_valid, o_dividend, o_count); end
    @(negedge i_clk); i_reset_n = 1;
    for (int k = 1; k <= 5; k++) cycle(1, k, 0, 1);
    checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(15 + RND)) begin errors++; $display("FAIL rmid_fresh: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, 15 + RND); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_sparse();
    int sum = 0, acc_n = 0, d;
    for (int k = 0; k < 10; k++) begin
      d = $urandom_range(0, 255);
      cycle(k % 2 == 0, d, 0, 1);
      if (k % 2 == 0) begin sum += d; acc_n++; end
      checks++; if (o_count !== CW'(acc_n % N)) begin errors++; $display("FAIL sparse_count: got %0d expected %0d", o_count, acc_n % N); end
      if (acc_n == N && k % 2 == 0) begin
        checks++; if (o_valid !== 1'b1 || o_dividend !== SUM_W'(sum + RND)) begin errors++; $display("FAIL sparse_sum: got valid=%0d sum=%0d expected valid=1 sum=%0d", o_valid, o_dividend, sum + RND); end
      end
    end
  endtask

  task automatic test_random();
    bit v, f, r;
    for (int k = 0; k < 3000; k++) begin
      v = $urandom_range(0, 3) != 0;
      f = $urandom_range(0, 31) == 0;
      r = $urandom_range(0, 2) == 0;
      cycle(v, $urandom_range(0, 255), f, r);
      checks++; if (o_valid !== mv) begin errors++; $display("FAIL rand_valid: cycle %0d got %0d expected %0d", k, o_valid, mv); end
      if (mv) begin
        checks++; if (o_dividend !== SUM_W'(md)) begin errors++; $display("FAIL rand_sum: cycle %0d got %0d expected %0d", k, o_dividend, md); end
      end
      checks++; if (o_count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", k, o_count, mq.size()); end
      checks++; if (o_ready !== model_ready(r)) begin errors++; $display("FAIL rand_ready: cycle %0d got %0d expected %0d", k, o_ready, model_ready(r)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_max_values();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_accumulator.md
# block_accumulator

- Upstream feeder for the `longDivision` stage.
- Accepts a stream of unsigned samples and sums each block of N consecutive samples.
- Each completed block sum is presented as a dividend/divisor pair to the divider through a valid/ready handshake, so the divider produces the block mean.
- Accumulation continues into the next block while the previous result waits in an output register; the input stalls only when both are full.

## Interface
- `DATA_W`, 8, sample width (unsigned).
- `N`, 5, samples per block; legal range 2..255.
- `SUM_W`, `DATA_W + $clog2(N)`, dividend/divisor width (derived; do not override).
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous and active-low.
- `i_flush`  in  1  synchronous; discards the partial block in progress.
- `i_valid`  in  1  input sample valid.
- `i_data`  in  DATA_W  input sample.
- `o_ready`  out  1  sample accepted when `i_valid && o_ready`.
- `o_valid`  out  1  dividend/divisor pair valid.
- `i_ready`  in  1  divider accepts the pair when `o_valid && i_ready`.
- `o_dividend`  out  SUM_W  block sum (optionally rounded).
- `o_divisor`  out  SUM_W  constant N, zero-extended.
- `o_count`  out  $clog2(N)  samples accumulated in the current block.

## Operation
- **Internal state:**
  - `acc` (SUM_W): running sum.
  - `cnt` (0..N-1): samples accumulated in the current block.
  - Output register `out_q`, with `o_valid` as its full flag.
- **Accept:** on `i_valid && o_ready`:
  - If `cnt < N-1`: `acc <= acc + i_data`, `cnt <= cnt + 1`.
  - If `cnt == N-1` (last sample): `out_q <= acc + i_data (+ rounding)`, `o_valid <= 1`, `acc <= 0`, `cnt <= 0`.
- **Output consume:** `o_valid && i_ready` with no block completing in the same cycle gives `o_valid <= 0`.
- **Simultaneous consume and completion:** `out_q` takes the new sum and `o_valid` stays 1.
- **Ready:** `o_ready = !(cnt == N-1 && o_valid && !i_ready)`.
  - Combinational from `i_ready` (single-cycle path, acceptable).
  - `o_ready` is 1 at all other times, including `cnt < N-1` regardless of output state.
- **Flush:** `i_flush` clears `acc` and `cnt` next edge.
  - Any sample offered in the same cycle is dropped, not accumulated.
  - `o_ready` is unaffected by `i_flush`.
  - `out_q` and `o_valid` are untouched; a pending result is still delivered.
- **Arithmetic:** unsigned throughout.
  - Maximum sum is N·(2^DATA_W−1) + N/2 < 2^SUM_W, so overflow is impossible and no saturation is needed.
- **Output stability:** `o_dividend` is stable while `o_valid && !i_ready`.
- **Divisor:** `o_divisor` is the constant N at all times, including reset.

## Timing
- **Reset values** (async assert, sync deassert expected from the system):
  - `acc = 0`, `cnt = 0`, `o_count = 0`
  - `o_valid = 0`, `o_dividend = 0`
  - `o_ready = 1` once reset is released; 0 while `i_reset_n` is low.
- **Latency:** `o_valid` rises on the edge that accepts the Nth sample; the pair is visible one cycle after the Nth handshake cycle.
- **Throughput:** one sample per cycle sustained when `i_ready` is never low for N−1 consecutive result-pending cycles.
- **Back-pressure:** while `o_valid && !i_ready`, up to N−1 further samples are accepted, then `o_ready` drops until consume.
- **Reset mid-block or mid-hold:** all state is cleared immediately; the pending result is lost and no partial sum is emitted.

## Configuration
- **`BLOCK_ACCUMULATOR_ROUND_EN` defined:**
  - Loaded dividend = sum + floor(N/2), so the truncating downstream divider yields round-half-up mean.
- **Not defined:**
  - Loaded dividend = raw sum; the divider yields the floor mean.
- The macro affects only the value loaded into `out_q`. Timing, ports and widths are identical in both builds.

## Test plan
1. **Single block:** N=5, reset, then feed 10, 20, 30, 40, 50 back-to-back with `i_ready=1`.
   - `o_valid` is high for exactly one cycle after the 5th accept.
   - `o_dividend` = 150 (152 with ROUND_EN); `o_divisor` = 5.
2. **Max values:** feed five samples of 255.
   - `o_dividend` = 1275 (1277 with ROUND_EN); no wrap in the 11-bit field.
3. **Back-pressure:** hold `i_ready=0`; stream 1..10 continuously.
   - First pair = 15, held stable.
   - `o_ready` drops once samples 6..9 have been accepted (`cnt` = 4).
   - Raise `i_ready`: sample 10 is accepted in that cycle and `o_valid` stays 1 with `o_dividend` = 40.
4. **Flush:** feed 7, 7, 7, then pulse `i_flush` together with `i_valid`, `i_data` = 99.
   - 99 is dropped and `o_count` → 0.
   - Next five samples of 2 give `o_dividend` = 10 (12 with ROUND_EN).
5. **Reset mid-operation:** with `o_valid=1` pending and `cnt=3`, drop `i_reset_n` mid-cycle.
   - `o_valid`, `o_dividend` and `o_count` go to 0 without waiting for a clock edge.
   - After release, a fresh block of 1, 2, 3, 4, 5 gives 15.
6. **Sparse input:** `i_valid` toggling 1-0-1-0.
   - Only handshaked samples count.
   - Result matches the sum of the accepted samples; `o_count` tracks accepts exactly.
